controlador_memoria_datos: RTL and testbench

Data-memory responder for the single-issue RISC-V core. Control decode drives MEM_RD and MEM_WR for load and store instructions. This block accepts those requests and performs the access on an internal word-organised synchronous RAM with configurable wait states. It returns load data (sign- or zero-extended) together with a one-cycle `listo` pulse and holds `stall` high while busy, so the datapath freezes the pipeline.

---
 rtl/controlador_memoria_datos_pkg.sv | 46 ++++
 rtl/memoria_datos_ram.sv | 25 ++
 rtl/controlador_memoria_datos.sv | 125 ++++++++++++
 tb/tb_controlador_memoria_datos.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/controlador_memoria_datos_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// request legality and store byte-lane selection.
package controlador_memoria_datos_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    ACCESO = 2'd2,
    RESP   = 2'd3
  } estado_t;

  // Exactly one of rd/wr, a funct3 defined for that direction, natural alignment.
  function automatic logic peticion_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lsb);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_BU:   ok = rd;
        F3_H:    ok = !lsb[0];
        F3_HU:   ok = rd && !lsb[0];
        F3_W:    ok = (lsb == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] habilitacion_bytes(input logic [2:0] f3, input logic [1:0] lsb);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lsb;
      2'b01:   be = lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/memoria_datos_ram.sv
// Single-port word RAM with synchronous read-first output and four byte write enables.
module memoria_datos_ram #(
  parameter int PROFUNDIDAD = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(PROFUNDIDAD)-1:0] dir,
  input  logic [31:0]                    dato_w,
  output logic [31:0]                    dato_r
);

  logic [31:0] mem [PROFUNDIDAD];

  // NOTE: the array has no reset; contents survive rst and the block maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (en) begin
      dato_r <= mem[dir];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[dir][8*i +: 8] <= dato_w[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/controlador_memoria_datos.sv
// Data-memory responder: accepts MEM_RD/MEM_WR from decode, runs the RAM access with
// LATENCIA wait states, returns extended load data with a one-cycle listo pulse.
module controlador_memoria_datos
  import controlador_memoria_datos_pkg::*;
#(
  parameter int PROFUNDIDAD = 1024,
  parameter int LATENCIA    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [2:0]  funct3,
  input  logic [31:0] direccion,
  input  logic [31:0] dato_escritura,
  output logic [31:0] dato_leido,
  output logic        listo,
  output logic        stall,
  output logic        error_acceso
);

  localparam int AW = $clog2(PROFUNDIDAD);

  estado_t     estado, estado_sig;
  logic [3:0]  cuenta;
  logic        h_wr, h_err;
  logic [2:0]  h_f3;
  logic [31:0] h_dir, h_dato;
  logic [31:0] dato_reg, dato_resp, ram_q, desplazado;
  logic        peticion, legal;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_dir;
  logic [31:0] ram_wd;

  assign peticion = MEM_RD | MEM_WR;
  assign legal    = peticion_legal(MEM_RD, MEM_WR, funct3, direccion[1:0]);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE: begin
        if (peticion) begin
          if (!legal)            estado_sig = RESP;
          else if (LATENCIA > 0) estado_sig = ESPERA;
          else                   estado_sig = ACCESO;
        end
      end
      ESPERA:  if (cuenta == 4'd0) estado_sig = ACCESO;
      ACCESO:  estado_sig = RESP;
      RESP:    estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= IDLE;
      cuenta   <= 4'd0;
      h_wr     <= 1'b0;
      h_err    <= 1'b0;
      h_f3     <= 3'b000;
      h_dir    <= 32'd0;
      h_dato   <= 32'd0;
      dato_reg <= 32'd0;
    end else begin
      estado <= estado_sig;
      if (estado == IDLE) begin
        h_wr   <= MEM_WR;
        h_err  <= peticion && !legal;
        h_f3   <= funct3;
        h_dir  <= direccion;
        h_dato <= dato_escritura;
      end
      if (estado == IDLE && estado_sig == ESPERA) cuenta <= 4'(LATENCIA - 1);
      else if (estado == ESPERA && cuenta != 4'd0) cuenta <= cuenta - 4'd1;
      if (estado == RESP) dato_reg <= dato_resp;
    end
  end

  // Word index wraps modulo the RAM depth; out-of-range addresses alias silently.
  assign ram_dir = AW'(h_dir[31:2] % 30'(PROFUNDIDAD));
  assign ram_we  = (estado == ACCESO && h_wr) ? habilitacion_bytes(h_f3, h_dir[1:0]) : 4'b0000;

  always_comb begin
    case (h_f3[1:0])
      2'b00:   ram_wd = {4{h_dato[7:0]}};
      2'b01:   ram_wd = {2{h_dato[15:0]}};
      default: ram_wd = h_dato;
    endcase
  end

  memoria_datos_ram #(.PROFUNDIDAD(PROFUNDIDAD)) u_ram (
    .clk    (clk),
    .en     (estado == ACCESO),
    .we     (ram_we),
    .dir    (ram_dir),
    .dato_w (ram_wd),
    .dato_r (ram_q)
  );

  // Legal accesses are naturally aligned, so one byte-granular shift serves all sizes.
  assign desplazado = ram_q >> {h_dir[1:0], 3'b000};

  always_comb begin
    dato_resp = 32'd0;
    if (!h_err && !h_wr) begin
      case (h_f3)
        F3_B:    dato_resp = {{24{desplazado[7]}}, desplazado[7:0]};
        F3_BU:   dato_resp = {24'd0, desplazado[7:0]};
        F3_H:    dato_resp = {{16{desplazado[15]}}, desplazado[15:0]};
        F3_HU:   dato_resp = {16'd0, desplazado[15:0]};
        F3_W:    dato_resp = desplazado;
        default: dato_resp = 32'd0;
      endcase
    end
  end

  assign listo        = (estado == RESP);
  assign error_acceso = listo && h_err;
  assign stall        = (estado == IDLE && peticion) || estado == ESPERA || estado == ACCESO;
  assign dato_leido   = listo ? dato_resp : dato_reg;

endmodule

// File: tb/tb_controlador_memoria_datos.sv
// Scoreboard bench: two instances (LATENCIA=0 and LATENCIA=3); stimulus pushes the
// expected response, a negedge monitor pops and compares on every listo pulse.
module tb_controlador_memoria_datos;
  import controlador_memoria_datos_pkg::*;

  localparam int LAT0 = 0;
  localparam int LAT1 = 3;

  typedef struct {
    logic [31:0] dato;
    logic        err;
    int          lat;
    int          stall_n;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v, rd_v, wr_v, listo_v, stall_v, err_v;
  logic [2:0]  f3_v  [2];
  logic [31:0] dir_v [2];
  logic [31:0] wd_v  [2];
  logic [31:0] dl_v  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   st_cnt[2];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controlador_memoria_datos #(.PROFUNDIDAD(1024), .LATENCIA(LAT0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .MEM_RD(rd_v[0]), .MEM_WR(wr_v[0]), .funct3(f3_v[0]),
    .direccion(dir_v[0]), .dato_escritura(wd_v[0]), .dato_leido(dl_v[0]),
    .listo(listo_v[0]), .stall(stall_v[0]), .error_acceso(err_v[0])
  );

  controlador_memoria_datos #(.PROFUNDIDAD(1024), .LATENCIA(LAT1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .MEM_RD(rd_v[1]), .MEM_WR(wr_v[1]), .funct3(f3_v[1]),
    .direccion(dir_v[1]), .dato_escritura(wd_v[1]), .dato_leido(dl_v[1]),
    .listo(listo_v[1]), .stall(stall_v[1]), .error_acceso(err_v[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input exp_t e, input int st);
    check($sformatf("dut%0d dato_leido", d), dl_v[d], e.dato);
    check($sformatf("dut%0d error_acceso", d), 32'(err_v[d]), 32'(e.err));
    check($sformatf("dut%0d latencia", d), 32'(cyc - e.t0), 32'(e.lat));
    check($sformatf("dut%0d ciclos stall", d), 32'(st), 32'(e.stall_n));
  endtask

  // Monitor: counts stall cycles per transaction and scores every listo pulse.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) st_cnt[d] = 0;
      else begin
        if (stall_v[d]) st_cnt[d]++;
        if (err_v[d] && !listo_v[d]) check($sformatf("dut%0d error sin listo", d), 32'd1, 32'd0);
        if (listo_v[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0)
            check($sformatf("dut%0d listo inesperado", d), 32'd1, 32'd0);
          else begin
            exp_t e;
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            cmp(d, e, st_cnt[d]);
          end
          st_cnt[d] = 0;
        end
      end
    end
  end

  task automatic drive(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    rd_v[d]  = rd;
    wr_v[d]  = wr;
    f3_v[d]  = f3;
    dir_v[d] = a;
    wd_v[d]  = wd;
  endtask

  task automatic req(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_err);
    exp_t e;
    int   l;
    bit   seen;
    @(posedge clk);
    #1;
    l = exp_err ? 1 : ((d == 0 ? LAT0 : LAT1) + 2);
    e = '{dato: exp_d, err: exp_err, lat: l, stall_n: l, t0: cyc};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(d, rd, wr, f3, a, wd);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = listo_v[d];
    end
    if (!seen) begin
      check($sformatf("dut%0d timeout listo", d), 32'd0, 32'd1);
      if (d == 0 && q0.size() > 0) void'(q0.pop_back());
      if (d == 1 && q1.size() > 0) void'(q1.pop_back());
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    if (seen) check($sformatf("dut%0d dato_leido retenido", d), dl_v[d], exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 2'b11;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset dato_leido", d), dl_v[d], 32'd0);
      check($sformatf("dut%0d reset listo", d), 32'(listo_v[d]), 32'd0);
      check($sformatf("dut%0d reset stall", d), 32'(stall_v[d]), 32'd0);
      check($sformatf("dut%0d reset error", d), 32'(err_v[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_v = 2'b00;

    // LATENCIA=0: store, load, extension
    req(0, 1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req(0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req(0, 1'b1, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    req(0, 1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    req(0, 1'b1, 1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    req(0, 1'b1, 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    // byte lane store: only low byte of the operand lands in lane 1
    req(0, 1'b0, 1'b1, F3_B,  32'h11, 32'hAABBCC55, 32'h0, 1'b0);
    req(0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    req(0, 1'b1, 1'b0, F3_B,  32'h11, 32'h0, 32'h00000055, 1'b0);
    // illegal requests
    req(0, 1'b1, 1'b0, F3_W,  32'h02, 32'h0, 32'h0, 1'b1);
    req(0, 1'b1, 1'b1, F3_W,  32'h10, 32'h11111111, 32'h0, 1'b1);
    req(0, 1'b1, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    req(0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    req(0, 1'b0, 1'b1, F3_H,  32'h11, 32'h22222222, 32'h0, 1'b1);
    req(0, 1'b0, 1'b1, F3_BU, 32'h10, 32'h33333333, 32'h0, 1'b1);
    // address 0x1010 aliases word 4 (0x10); also proves rejected stores left no trace
    req(0, 1'b1, 1'b0, F3_W,  32'h1010, 32'h0, 32'hDEAD55EF, 1'b0);

    // LATENCIA=3: wait states, then reset in ESPERA
    req(1, 1'b0, 1'b1, F3_W,  32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    req(1, 1'b1, 1'b0, F3_W,  32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b1, F3_W, 32'h0, 32'h12345678);
    @(posedge clk);
    #1;
    rst_v[1] = 1'b1;
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_v[1] = 1'b0;
    @(negedge clk);
    check("dut1 tras reset dato_leido", dl_v[1], 32'd0);
    check("dut1 tras reset listo", 32'(listo_v[1]), 32'd0);
    check("dut1 tras reset stall", 32'(stall_v[1]), 32'd0);
    check("dut1 tras reset error", 32'(err_v[1]), 32'd0);
    repeat (6) @(negedge clk);
    check("dut1 sin listo tras reset", 32'(listo_v[1]), 32'd0);
    req(1, 1'b1, 1'b0, F3_W,  32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (3) @(negedge clk);
    check("dut0 cola pendiente", 32'(q0.size()), 32'd0);
    check("dut1 cola pendiente", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
